// File: rtl/regfile_dump_if.sv
// regfile_dump_if - control, register-file read port and output stream of the
// register dump reader, bundled so the reader and its consumer share one port.
//
// Optional feature macro: REGDUMP_CHECKSUM_EN (adds the checksum signal).
//
// Signals:
//   start      request to begin a dump (one-cycle pulse)
//   busy       dump in progress
//   done       one-cycle pulse after the final word handshakes
//   rf_raddr   register file read address
//   rf_rdata   register file read data (combinational from rf_raddr)
//   out_valid  stream head valid
//   out_ready  consumer accepts the head
//   out_addr   register address of the head word
//   out_data   register value of the head word
//   out_last   head is the final word of the dump
//   checksum   running XOR of dumped data (REGDUMP_CHECKSUM_EN only)
//
// Modports: master = the dump reader, slave = the consumer / register file side.
interface regfile_dump_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  modport master (
    input  start, rf_rdata, out_ready,
    output busy, done, rf_raddr, out_valid, out_addr, out_data, out_last
`ifdef REGDUMP_CHECKSUM_EN
    , output checksum
`endif
  );

  modport slave (
    output start, rf_rdata, out_ready,
    input  busy, done, rf_raddr, out_valid, out_addr, out_data, out_last
`ifdef REGDUMP_CHECKSUM_EN
    , input checksum
`endif
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader - on a start pulse, walks the register file read port from
// FIRST_ADDR to LAST_ADDR and streams (addr, data) pairs out through a 2-entry
// FIFO over a valid/ready handshake. Intended for register dumps in sim/debug.
//
// Optional feature macro: REGDUMP_CHECKSUM_EN
//   When defined, a running XOR of the dumped data is kept on bus.checksum and an
//   extra trailing word (addr 0, data = final XOR) is emitted as the last word.
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    regfile_dump_if.master: start/busy/done, rf_raddr/rf_rdata,
//          out_valid/out_ready/out_addr/out_data/out_last (+ checksum)
//
// Parameters: DATA_W, ADDR_W, FIRST_ADDR, LAST_ADDR
//   (FIRST_ADDR <= LAST_ADDR < 2**ADDR_W is required).
module regfile_dump_reader #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIRST_ADDR = 0,
  parameter int LAST_ADDR  = 31
) (
  input logic             clk,
  input logic             rst_n,
  regfile_dump_if.master  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);

  logic [1:0]        state;
  logic [ADDR_W-1:0] raddr;
  logic              done_q;

  // FIFO storage: e0 is always the head, e1 the second entry.
  logic [1:0]        count;
  logic [ADDR_W-1:0] e0_addr, e1_addr;
  logic [DATA_W-1:0] e0_data, e1_data;
  logic              e0_last, e1_last;

  logic              pop;
  logic              push;
  logic              at_last;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;
  logic              push_last;

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
  // Set after the LAST_ADDR push: the next push is the checksum trailer word.
  logic              csum_pend;
`endif

  // A full FIFO still accepts a push when its head leaves in the same cycle.
  always_comb begin
    pop       = (count != 2'd0) && bus.out_ready;
    at_last   = (raddr == LAST_A);
    push      = (state == S_READ) && ((count != 2'd2) || pop);
    push_addr = raddr;
    push_data = bus.rf_rdata;
`ifdef REGDUMP_CHECKSUM_EN
    push_last = csum_pend;
    if (csum_pend) begin
      push_addr = '0;
      push_data = csum;
    end
`else
    push_last = at_last;
`endif
  end

  // The address never wraps: it holds at LAST_ADDR, which also keeps the
  // comparison safe when LAST_ADDR is the top of the address space.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      raddr     <= FIRST_A;
      done_q    <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum      <= '0;
      csum_pend <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state     <= S_READ;
            raddr     <= FIRST_A;
`ifdef REGDUMP_CHECKSUM_EN
            csum      <= '0;
            csum_pend <= 1'b0;
`endif
          end
        end
        S_READ: begin
          if (push) begin
`ifdef REGDUMP_CHECKSUM_EN
            if (csum_pend) begin
              state     <= S_DRAIN;
              csum_pend <= 1'b0;
            end else begin
              csum <= csum ^ bus.rf_rdata;
              if (at_last) csum_pend <= 1'b1;
              else         raddr     <= raddr + ADDR_W'(1);
            end
`else
            if (at_last) state <= S_DRAIN;
            else         raddr <= raddr + ADDR_W'(1);
`endif
          end
        end
        S_DRAIN: begin
          if (pop && e0_last) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO update. With push and pop together the occupancy is unchanged and the
  // new word lands behind whatever remains after the head leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= 2'd0;
      e0_addr <= '0;
      e0_data <= '0;
      e0_last <= 1'b0;
      e1_addr <= '0;
      e1_data <= '0;
      e1_last <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            e0_addr <= push_addr;
            e0_data <= push_data;
            e0_last <= push_last;
          end else begin
            e1_addr <= push_addr;
            e1_data <= push_data;
            e1_last <= push_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) begin
            e0_addr <= e1_addr;
            e0_data <= e1_data;
            e0_last <= e1_last;
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0_addr <= push_addr;
            e0_data <= push_data;
            e0_last <= push_last;
          end else begin
            e0_addr <= e1_addr;
            e0_data <= e1_data;
            e0_last <= e1_last;
            e1_addr <= push_addr;
            e1_data <= push_data;
            e1_last <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = done_q;
  assign bus.rf_raddr  = raddr;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_addr  = e0_addr;
  assign bus.out_data  = e0_data;
  assign bus.out_last  = e0_last;
`ifdef REGDUMP_CHECKSUM_EN
  assign bus.checksum  = csum;
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader - self-checking bench for regfile_dump_reader.
// Register file model r[i] = 16 + i, table-driven full-dump vectors plus
// hand-written reset, backpressure, alternating-ready and double-start sequences.
// Honours REGDUMP_CHECKSUM_EN (expects the extra checksum trailer word).
module tb_regfile_dump_reader;

`ifdef REGDUMP_CHECKSUM_EN
  localparam int NW = 33;
`else
  localparam int NW = 32;
`endif

  typedef struct {
    logic        start;
    logic        ready;
    logic        exp_valid;
    logic [37:0] exp_word;
    logic        exp_done;
    logic        exp_busy;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] regs [32];
  logic [31:0] xor_all;

  int n_checks = 0;
  int n_fail   = 0;

  logic [37:0] got [$];
  int          done_cnt   = 0;
  int          done_words = 0;

  vec_t vecs [40];

  regfile_dump_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  assign bus.rf_rdata = regs[bus.rf_raddr];

  regfile_dump_reader #(
    .DATA_W(32), .ADDR_W(5), .FIRST_ADDR(0), .LAST_ADDR(31)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  // Records every handshake (inputs are stable between negedge and posedge).
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready)
        got.push_back({bus.out_addr, bus.out_data, bus.out_last});
      if (bus.done) begin
        done_cnt   = done_cnt + 1;
        done_words = got.size();
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r);
    @(posedge clk);
    #1;
    bus.start     = s;
    bus.out_ready = r;
  endtask

  function automatic logic [37:0] expWord(input int k);
    logic [4:0]  a;
    logic [31:0] d;
    logic        l;
    if (k < 32) begin
      a = 5'(k);
      d = 32'(16 + k);
    end else begin
      a = 5'd0;
      d = xor_all;
    end
    l = (k == NW - 1);
    return {a, d, l};
  endfunction

  task automatic clearLog();
    got.delete();
    done_cnt   = 0;
    done_words = 0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " busy"},      64'(bus.busy), 0);
    checkOutput({tag, " done"},      64'(bus.done), 0);
    checkOutput({tag, " out_valid"}, 64'(bus.out_valid), 0);
    checkOutput({tag, " out_addr"},  64'(bus.out_addr), 0);
    checkOutput({tag, " out_data"},  64'(bus.out_data), 0);
    checkOutput({tag, " out_last"},  64'(bus.out_last), 0);
    checkOutput({tag, " rf_raddr"},  64'(bus.rf_raddr), 0);
`ifdef REGDUMP_CHECKSUM_EN
    checkOutput({tag, " checksum"},  64'(bus.checksum), 0);
`endif
  endtask

  task automatic checkSequence(input string tag);
    checkOutput({tag, " word count"}, 64'(got.size()), 64'(NW));
    for (int k = 0; k < got.size() && k < NW; k++)
      checkOutput($sformatf("%s word%0d", tag, k), 64'(got[k]), 64'(expWord(k)));
    checkOutput({tag, " done pulses"}, 64'(done_cnt), 1);
    checkOutput({tag, " words before done"}, 64'(done_words), 64'(NW));
  endtask

  task automatic waitDone(input string tag, input int limit);
    int i = 0;
    while (done_cnt == 0 && i < limit) begin
      applyStimulus(1'b0, 1'b1);
      @(negedge clk);
      i++;
    end
    checkOutput({tag, " done seen"}, 64'(done_cnt != 0), 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(16 + i);
    xor_all = '0;
    for (int i = 16; i <= 47; i++) xor_all = xor_all ^ 32'(i);

    for (int c = 0; c < 40; c++) begin
      vecs[c].start     = (c == 0);
      vecs[c].ready     = 1'b1;
      vecs[c].exp_valid = (c >= 2) && (c <= NW + 1);
      vecs[c].exp_word  = vecs[c].exp_valid ? expWord(c - 2) : 38'd0;
      vecs[c].exp_done  = (c == NW + 2);
      vecs[c].exp_busy  = (c >= 1) && (c <= NW + 1);
    end

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    checkResetOutputs("por");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Full dump, out_ready held high, cycle-accurate table.
    $display("[TB] full dump table");
    clearLog();
    for (int c = 0; c < NW + 4; c++) begin
      applyStimulus(vecs[c].start, vecs[c].ready);
      @(negedge clk);
      checkOutput($sformatf("vec%0d valid", c), 64'(bus.out_valid), 64'(vecs[c].exp_valid));
      checkOutput($sformatf("vec%0d busy", c),  64'(bus.busy),      64'(vecs[c].exp_busy));
      checkOutput($sformatf("vec%0d done", c),  64'(bus.done),      64'(vecs[c].exp_done));
      if (vecs[c].exp_valid)
        checkOutput($sformatf("vec%0d word", c),
                    64'({bus.out_addr, bus.out_data, bus.out_last}), 64'(vecs[c].exp_word));
    end
`ifdef REGDUMP_CHECKSUM_EN
    checkOutput("checksum port", 64'(bus.checksum), 64'(xor_all));
`endif
    checkSequence("full");
    idle(3);

    // Backpressure: consumer stalled for 10 cycles after start.
    $display("[TB] backpressure");
    clearLog();
    applyStimulus(1'b1, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(1'b0, 1'b0);
      @(negedge clk);
      if (c >= 2)
        checkOutput($sformatf("bp c%0d head", c),
                    64'({bus.out_valid, bus.out_addr, bus.out_data}), 64'({1'b1, 5'd0, 32'd16}));
    end
    checkOutput("bp rf_raddr held", 64'(bus.rf_raddr), 2);
    checkOutput("bp busy", 64'(bus.busy), 1);
    waitDone("bp", 200);
    idle(3);
    checkSequence("bp");

    // Alternating out_ready 1,0,1,0...
    $display("[TB] alternating ready");
    clearLog();
    applyStimulus(1'b1, 1'b1);
    for (int i = 1; i < 300 && done_cnt == 0; i++) begin
      applyStimulus(1'b0, (i % 2) == 0);
      @(negedge clk);
    end
    checkOutput("alt done seen", 64'(done_cnt != 0), 1);
    idle(3);
    checkSequence("alt");

    // Second start while busy must be ignored.
    $display("[TB] start while busy");
    clearLog();
    for (int c = 0; c <= 5; c++) applyStimulus((c == 0) || (c == 5), 1'b1);
    @(negedge clk);
    checkOutput("dbl busy at c5", 64'(bus.busy), 1);
    waitDone("dbl", 200);
    idle(6);
    checkSequence("dbl");

    // Reset in the middle of a dump.
    $display("[TB] reset mid-dump");
    clearLog();
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 50 && got.size() < 5; i++) begin
      applyStimulus(1'b0, 1'b1);
      @(negedge clk);
    end
    checkOutput("rst words before reset", 64'(got.size() >= 5), 1);
    #2 rst_n = 1'b0;
    #1;
    checkResetOutputs("rst async");
    clearLog();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("rst idle c%0d", c), 64'({bus.out_valid, bus.busy}), 0);
    end
    checkOutput("rst no stray words", 64'(got.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
